rf_scb: RTL
===========

# rf_scb

Parametrised general-purpose register file for the RISC-V core with a configurable number of read ports, optional write-to-read bypass and an integrated busy scoreboard. It replaces the fixed two-read-port file between decode and writeback. The scoreboard tracks destination registers with in-flight writes, so decode can detect RAW/WAW hazards without a separate unit. x0 is hardwired to zero and is never busy.

## Interface
- NREG, 32, number of architectural registers including x0 (power of two, ≥2)
- REGW, 32, register width in bits
- AW, $clog2(NREG), register address width
- NRP, 2, number of read ports (1..4)
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports
- RSTVAL, {REGW{1'b0}}, value loaded into x1..x(NREG-1) on reset
- clk  in  1  clock; all state updates on posedge
- arst_n  in  1  reset, asynchronous, active-low
- srst  in  1  synchronous reset, active-high, same effect as arst_n
- ra  in  NRP*AW  read addresses; port p uses bits [p*AW +: AW]
- rd  out  NRP*REGW  read data, port p at [p*REGW +: REGW]
- rbusy  out  NRP  port p source has a pending write
- iss_v  in  1  decode requests ownership of destination iss_a
- iss_a  in  AW  destination register being issued
- iss_rdy  out  1  issue may be accepted this cycle
- we  in  1  writeback valid
- wa  in  AW  writeback address
- wd  in  REGW  writeback data
- busy_cnt  out  AW+1  registered count of busy registers

## Operation
- State: regs[1..NREG-1] (REGW each), busy[1..NREG-1], busy_cnt. No storage for x0.
- Reset (arst_n low or srst high on a clock edge): regs ← RSTVAL, busy ← 0, busy_cnt ← 0. srst beats we and issue in the same cycle.
- Write: we && wa≠0 → regs[wa] ← wd and busy[wa] ← 0. A write to x0 is dropped. A write to a non-busy register is legal and updates data.
- Issue: accepted when iss_v && iss_rdy; if iss_a≠0 sets busy[iss_a]. iss_rdy = (iss_a==0) || !busy[iss_a] || (we && wa==iss_a). A not-ready issue has no effect; decode holds iss_v/iss_a.
- Same register, same cycle: write + accepted issue → data written, busy ends at 1 (the new owner wins).
- Read port p: ra_p==0 → rd=0, rbusy=0. BYPASS=1 and we && wa==ra_p → rd=wd, rbusy=0. Otherwise rd=regs[ra_p], rbusy=busy[ra_p].
- busy_cnt: +1 on an accepted issue that sets a previously clear bit; −1 on a write that clears a set bit not re-set that cycle; both together on different registers → unchanged. Never wraps; max NREG-1.

## Timing
- Reads, rbusy and iss_rdy are combinational from state and current inputs; no read latency.
- A write is visible on rd in the same cycle with BYPASS=1, otherwise the next cycle.
- Busy set by an issue is visible on rbusy/iss_rdy the cycle after acceptance.
- busy_cnt reflects the busy vector one cycle after the changing edge (same edge as busy).
- Outputs at reset: rd = RSTVAL for nonzero addresses, 0 for x0; rbusy=0; iss_rdy=1; busy_cnt=0.
- arst_n assertion mid-operation clears state immediately regardless of clk; deassertion is synchronised externally.

## Structure
- Shared package rf_pkg: NREG, REGW, AW, ZERO constant, default RSTVAL, reg-address typedef.
- Sub-module rf_scb_busy: busy vector, issue/clear arbitration, iss_rdy, busy_cnt. The top level holds data storage, read muxes and bypass.

## Test plan
- Reset with RSTVAL=32'h0000_0000 → all ports read 0, rbusy=0, iss_rdy=1, busy_cnt=0.
- Write x3=32'hcafebabe; next cycle ra0=3, ra1=0 → rd0=cafebabe, rd1=0; write to x0=32'hffff_ffff → x0 still reads 0.
- BYPASS=1: we, wa=5, wd=32'h1234_5678 with ra0=5 same cycle → rd0=12345678, rbusy0=0; BYPASS=0 → old value that cycle, new value next.
- Issue x7 → next cycle rbusy=1 on ra=7, busy_cnt=1; second issue x7 → iss_rdy=0; write x7 → busy clears, busy_cnt=0.
- Issue x9 with a simultaneous write to x9 → iss_rdy=1, data written, busy[9]=1 after, busy_cnt unchanged at its prior value +1 only if x9 was clear.
- Busy x2,x4, pulse arst_n low between clock edges → busy_cnt=0, regs=RSTVAL immediately; srst with we=1 → write is ignored.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and types for the register file with integrated busy scoreboard.
package rf_pkg;

    localparam int unsigned RF_NREG = 32;
    localparam int unsigned RF_REGW = 32;
    localparam int unsigned RF_AW   = $clog2(RF_NREG);

    localparam logic [RF_REGW-1:0] RF_ZERO   = '0;
    localparam logic [RF_REGW-1:0] RF_RSTVAL = RF_ZERO;

    typedef logic [RF_AW-1:0] reg_addr_t;

endpackage

// File: rtl/rf_scb_busy.sv
// Busy scoreboard: per-register pending-write bits, issue/clear arbitration and busy count.
module rf_scb_busy
    import rf_pkg::*;
#(
    parameter int unsigned NREG = RF_NREG,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            arst_ni,
    input  logic            srst_i,
    input  logic            iss_v_i,
    input  logic [AW-1:0]   iss_a_i,
    input  logic            we_i,
    input  logic [AW-1:0]   wa_i,
    output logic            iss_rdy_o,
    output logic [NREG-1:0] busy_o,
    output logic [AW:0]     busy_cnt_o
);

    logic [NREG-1:1] busy_q, busy_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [NREG-1:0] busy_full, busy_nxt;
    logic            iss_acc, wr_clr, cnt_inc, cnt_dec;

    // x0 never owns a busy bit
    assign busy_full = {busy_q, 1'b0};

    always_comb begin
        iss_rdy_o = (iss_a_i == '0) || !busy_full[iss_a_i] || (we_i && (wa_i == iss_a_i));
        iss_acc   = iss_v_i && iss_rdy_o && (iss_a_i != '0);
        wr_clr    = we_i && (wa_i != '0);

        // Issue applied after the clear so a same-register issue wins
        busy_nxt = busy_full;
        if (wr_clr) begin
            busy_nxt[wa_i] = 1'b0;
        end
        if (iss_acc) begin
            busy_nxt[iss_a_i] = 1'b1;
        end
        busy_d = busy_nxt[NREG-1:1];

        cnt_inc = iss_acc && !busy_full[iss_a_i];
        cnt_dec = wr_clr && busy_full[wa_i] && !(iss_acc && (iss_a_i == wa_i));

        cnt_d = cnt_q;
        if (cnt_inc && !cnt_dec) begin
            cnt_d = cnt_q + {{AW{1'b0}}, 1'b1};
        end else if (cnt_dec && !cnt_inc) begin
            cnt_d = cnt_q - {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else if (srst_i) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_full;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/rf_scb.sv
// Register file with configurable read ports, optional write bypass and busy scoreboard.
module rf_scb
    import rf_pkg::*;
#(
    parameter int unsigned NREG   = RF_NREG,
    parameter int unsigned REGW   = RF_REGW,
    parameter int unsigned AW     = $clog2(NREG),
    parameter int unsigned NRP    = 2,
    parameter int unsigned BYPASS = 1,
    parameter logic [REGW-1:0] RSTVAL = REGW'(RF_RSTVAL)
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                srst,
    input  logic [NRP*AW-1:0]   ra,
    output logic [NRP*REGW-1:0] rd,
    output logic [NRP-1:0]      rbusy,
    input  logic                iss_v,
    input  logic [AW-1:0]       iss_a,
    output logic                iss_rdy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [REGW-1:0]     wd,
    output logic [AW:0]         busy_cnt
);

    logic [REGW-1:0] regs_q [NREG-1:1];
    logic [NREG-1:0] busy;
    logic [AW-1:0]   rd_a;

    rf_scb_busy #(
        .NREG (NREG),
        .AW   (AW)
    ) u_busy (
        .clk_i      (clk),
        .arst_ni    (arst_n),
        .srst_i     (srst),
        .iss_v_i    (iss_v),
        .iss_a_i    (iss_a),
        .we_i       (we),
        .wa_i       (wa),
        .iss_rdy_o  (iss_rdy),
        .busy_o     (busy),
        .busy_cnt_o (busy_cnt)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= RSTVAL;
            end
        end else if (srst) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= RSTVAL;
            end
        end else if (we && (wa != '0)) begin
            regs_q[wa] <= wd;
        end
    end

    // x0 reads zero and is never busy; a forwarded write is by definition no longer pending
    always_comb begin
        rd    = '0;
        rbusy = '0;
        rd_a  = '0;
        for (int p = 0; p < NRP; p++) begin
            rd_a = ra[p*AW +: AW];
            if (rd_a == '0) begin
                rd[p*REGW +: REGW] = '0;
            end else if ((BYPASS != 0) && we && (wa == rd_a)) begin
                rd[p*REGW +: REGW] = wd;
            end else begin
                rd[p*REGW +: REGW] = regs_q[rd_a];
                rbusy[p]           = busy[rd_a];
            end
        end
    end

endmodule
